// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, baud table and FSM state type for the UART receive path
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  localparam int BAUD_RATES [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_EVAL
  } rx_state_e;

  // Round to nearest; a divider below 1 would never tick.
  function automatic int baud_divider(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// rtl/uart_rx_baud_gen.sv - 16x oversample tick generator selected by baud_select
module baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_select,
  output logic       sample_tick
);

  typedef logic [15:0] cnt_t;

  localparam cnt_t DIV_M1 [8] = '{
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[0]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[1]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[2]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[3]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[4]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[5]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[6]) - 1),
    cnt_t'(baud_divider(CLK_FREQ_HZ, BAUD_RATES[7]) - 1)
  };

  cnt_t       count_q, count_d;
  logic [2:0] sel_q, sel_d;
  logic       sel_change;
  logic       tick;

  always_comb begin
    sel_d      = baud_select;
    sel_change = (baud_select != sel_q);
    // A rate change restarts the period, so no tick is issued on that cycle.
    tick       = !sel_change && (count_q == DIV_M1[baud_select]);
    if (sel_change || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sel_q   <= '0;
    end else begin
      count_q <= count_d;
      sel_q   <= sel_d;
    end
  end

  assign sample_tick = tick;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8E1 UART receiver with 16x oversampling, framing and parity flags
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           baud_select,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ferror,
  output logic                 rx_perror,
  output logic                 rx_valid
);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] START_PT = 4'd8;
  localparam logic [3:0] BIT_PT   = 4'd0;
  localparam logic [3:0] S_RELOAD = 4'd1;
`else
  localparam logic [3:0] START_PT = 4'd7;
  localparam logic [3:0] BIT_PT   = 4'd15;
  localparam logic [3:0] S_RELOAD = 4'd0;
`endif

  logic                 tick;
  logic                 sync1_q, sync2_q;
  rx_state_e            state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic [2:0]           sel_q, sel_d;
  logic                 rxs;
  logic                 samp;

  baud_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .baud_select(baud_select),
    .sample_tick(tick)
  );

  assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // v0/v1 hold the two previous tick samples; with rxs they form the vote window.
  logic v0_q, v1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b1;
      v1_q <= 1'b1;
    end else if (tick) begin
      v0_q <= v1_q;
      v1_q <= rxs;
    end
  end
  assign samp = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
`else
  assign samp = rxs;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    sel_d   = baud_select;

    if (!rx_en || (baud_select != sel_q)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick && !rxs) begin
            state_d = ST_START;
            s_d     = 4'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == START_PT) begin
              if (samp) begin
                state_d = ST_IDLE;
              end else begin
                state_d = ST_DATA;
                s_d     = S_RELOAD;
                bit_d   = 3'd0;
                ferr_d  = 1'b0;
                perr_d  = 1'b0;
              end
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == BIT_PT) begin
              shift_d = {samp, shift_q[DATA_BITS-1:1]};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == BIT_PT) begin
              par_d   = samp;
              state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == BIT_PT) begin
              stop_d  = samp;
              state_d = ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          state_d = ST_IDLE;
          perr_d  = ^{shift_q, par_q};
          ferr_d  = ~stop_q;
          if (stop_q && !(^{shift_q, par_q})) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b1;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_ferror = ferr_q;
  assign rx_perror = perr_q;
  assign rx_valid  = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx
module tb_uart_rx;

  // Main DUT runs from a slow clock so the 300-baud sweep stays short; dividers below are
  // round(921600 / (16 * baud)) for 300..115200.
  localparam int TB_CLK = 921_600;
  localparam int DIVS [8] = '{192, 48, 12, 6, 3, 2, 1, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud_select;
  logic       rx_en;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_ferror, rx_perror, rx_valid;

  logic [2:0] ref_sel;
  logic [7:0] ref_data;
  logic       ref_ferror, ref_perror, ref_valid;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cur_div  = 1;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ_HZ(TB_CLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_select(baud_select),
    .rx_en      (rx_en),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_ferror  (rx_ferror),
    .rx_perror  (rx_perror),
    .rx_valid   (rx_valid)
  );

  // Default 100 MHz instance, used only to measure tick spacing.
  uart_rx dut_ref (
    .clk        (clk),
    .rst        (rst),
    .baud_select(ref_sel),
    .rx_en      (1'b0),
    .rxd        (1'b1),
    .rx_data    (ref_data),
    .rx_ferror  (ref_ferror),
    .rx_perror  (ref_perror),
    .rx_valid   (ref_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      chk("valid_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("rx_data_on_valid", 32'(rx_data), 32'(exp_q.pop_front()));
        chk("flags_on_valid", 32'({rx_ferror, rx_perror}), 32'd0);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (16 * cur_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(st);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic set_rate(input int sel);
    baud_select = 3'(sel);
    cur_div     = DIVS[sel];
    repeat (4) @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_data"}, 32'(rx_data), 32'(d));
    chk({tag, "_flags"}, 32'({rx_ferror, rx_perror}), 32'({fe, pe}));
  endtask

  task automatic measure_tick(input int sel, input int exp_div);
    int n;
    ref_sel = 3'(sel);
    @(negedge clk);
    n = 0;
    while (!dut_ref.u_baud.sample_tick && n < 30000) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    @(negedge clk);
    while (!dut_ref.u_baud.sample_tick && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("tick_spacing", 32'(n), 32'(exp_div));
  endtask

  initial begin
    rst         = 1'b1;
    rx_en       = 1'b0;
    rxd         = 1'b1;
    baud_select = 3'd7;
    ref_sel     = 3'd7;
    cur_div     = DIVS[7];
    repeat (5) @(negedge clk);
    chk("reset_data", 32'(rx_data), 32'd0);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_flags", 32'({rx_ferror, rx_perror}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_outputs", 32'({rx_valid, rx_ferror, rx_perror, rx_data}), 32'd0);

    rx_en = 1'b1;
    set_rate(7);
    exp_q.push_back(8'hAA); send_frame(8'hAA, 1'b0, 1'b1);
    check_state("frame_aa", 8'hAA, 1'b0, 1'b0);
    exp_q.push_back(8'h55); send_frame(8'h55, 1'b0, 1'b1);
    check_state("frame_55", 8'h55, 1'b0, 1'b0);
    exp_q.push_back(8'hCC); send_frame(8'hCC, 1'b0, 1'b1);
    check_state("frame_cc", 8'hCC, 1'b0, 1'b0);

    exp_q.push_back(8'h89); send_frame(8'h89, 1'b1, 1'b1);
    check_state("frame_89_good", 8'h89, 1'b0, 1'b0);
    send_frame(8'h89, 1'b0, 1'b1);
    check_state("frame_89_bad_parity", 8'h89, 1'b0, 1'b1);

    set_rate(3);
    send_frame(8'h55, 1'b0, 1'b0);
    check_state("frame_55_bad_stop", 8'h89, 1'b1, 1'b0);

    set_rate(7);
    exp_q.push_back(8'hAA); send_frame(8'hAA, 1'b0, 1'b1);
    check_state("flags_cleared", 8'hAA, 1'b0, 1'b0);

    rxd = 1'b0;
    repeat (4 * cur_div) @(negedge clk);
    rxd = 1'b1;
    repeat (32 * cur_div) @(negedge clk);
    check_state("glitch", 8'hAA, 1'b0, 1'b0);
    exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b0, 1'b1);
    check_state("after_glitch", 8'h3C, 1'b0, 1'b0);

    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx_en = 1'b0;
    for (int i = 4; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_en = 1'b1;
    drive_bit(1'b1);
    check_state("rx_en_abort", 8'h3C, 1'b0, 1'b0);
    exp_q.push_back(8'h0F); send_frame(8'h0F, 1'b0, 1'b1);
    check_state("after_abort", 8'h0F, 1'b0, 1'b0);

    for (int s = 0; s < 8; s++) begin
      set_rate(s);
      exp_q.push_back(8'hAA);
      send_frame(8'hAA, 1'b0, 1'b1);
      check_state("sweep", 8'hAA, 1'b0, 1'b0);
    end

    measure_tick(7, 54);
    measure_tick(6, 109);
    measure_tick(3, 651);
    chk("ref_outputs_idle", 32'({ref_valid, ref_ferror, ref_perror, ref_data}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
